// File: rtl/dest_tracker_pkg.sv
// Shared pipeline definitions for the MEM/WB destination tracker.
package pipe_pkg;

  localparam int         XLEN_DEF = 32;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       reg_write;
    logic       mem_read;
  } stage_ctrl_t;

endpackage

// File: rtl/dest_tracker_if.sv
// EX/ID/memory-side inputs and MEM/WB tracking outputs of the destination tracker.
interface dest_tracker_if
  import pipe_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) ();

  logic            ex_valid;
  logic            ex_flush;
  logic [4:0]      ex_rd_addr;
  logic            ex_reg_write;
  logic            ex_mem_read;
  logic [XLEN-1:0] ex_result;
  logic [4:0]      id_rs1_addr;
  logic [4:0]      id_rs2_addr;
  logic            mem_ready;
  logic [XLEN-1:0] mem_rdata;

  logic [4:0]      MEM_write_addr;
  logic [4:0]      WB_write_addr;
  logic            MEM_RegWrite;
  logic            WB_RegWrite;
  logic [XLEN-1:0] MEM_fwd_data;
  logic [XLEN-1:0] WB_data;
  logic            load_use_stall;
  logic            mem_stall;
  logic [15:0]     stall_count;

  modport master (
    output ex_valid, ex_flush, ex_rd_addr, ex_reg_write, ex_mem_read, ex_result,
    output id_rs1_addr, id_rs2_addr, mem_ready, mem_rdata,
    input  MEM_write_addr, WB_write_addr, MEM_RegWrite, WB_RegWrite,
    input  MEM_fwd_data, WB_data, load_use_stall, mem_stall, stall_count
  );

  modport slave (
    input  ex_valid, ex_flush, ex_rd_addr, ex_reg_write, ex_mem_read, ex_result,
    input  id_rs1_addr, id_rs2_addr, mem_ready, mem_rdata,
    output MEM_write_addr, WB_write_addr, MEM_RegWrite, WB_RegWrite,
    output MEM_fwd_data, WB_data, load_use_stall, mem_stall, stall_count
  );

endinterface

// File: rtl/dest_tracker_stage_reg.sv
// One pipeline stage record with hold (freeze) and bubble (invalidate on load) controls.
module stage_reg
  import pipe_pkg::*;
#(
  parameter int W = XLEN_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold_i,
  input  logic        bubble_i,
  input  stage_ctrl_t ctrl_d_i,
  input  logic [W-1:0] data_d_i,
  output stage_ctrl_t ctrl_q_o,
  output logic [W-1:0] data_q_o
);

  stage_ctrl_t  ctrl_q;
  logic [W-1:0] data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q <= '0;
      data_q <= '0;
    end else if (!hold_i) begin
      ctrl_q <= '{valid:     ctrl_d_i.valid & ~bubble_i,
                  rd:        ctrl_d_i.rd,
                  reg_write: ctrl_d_i.reg_write,
                  mem_read:  ctrl_d_i.mem_read};
      data_q <= data_d_i;
    end
  end

  assign ctrl_q_o = ctrl_q;
  assign data_q_o = data_q;

endmodule

// File: rtl/dest_tracker.sv
// Tracks MEM/WB destinations for forwarding, and raises load-use and memory-wait stalls.
module dest_tracker
  import pipe_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic           clk,
  input  logic           rst,
  dest_tracker_if.slave  bus
);

  stage_ctrl_t     ex_ctrl, mem_ctrl, wb_ctrl;
  logic [XLEN-1:0] mem_data, wb_data, wb_data_d;
  logic            mem_stall, load_use;
  logic [15:0]     stall_cnt_q, stall_cnt_d;

  assign ex_ctrl = '{valid:     bus.ex_valid & ~bus.ex_flush,
                     rd:        bus.ex_rd_addr,
                     reg_write: bus.ex_reg_write,
                     mem_read:  bus.ex_mem_read};

  assign mem_stall = mem_ctrl.valid & mem_ctrl.mem_read & ~bus.mem_ready;

  // A memory wait freezes EX too, so it overrides any load-use request.
  assign load_use = ~mem_stall & ex_ctrl.valid & bus.ex_mem_read & bus.ex_reg_write &
                    (bus.ex_rd_addr != REG_ZERO) &
                    ((bus.ex_rd_addr == bus.id_rs1_addr) || (bus.ex_rd_addr == bus.id_rs2_addr));

  assign wb_data_d = mem_ctrl.mem_read ? bus.mem_rdata : mem_data;

  stage_reg #(.W(XLEN)) u_mem (
    .clk      (clk),
    .rst      (rst),
    .hold_i   (mem_stall),
    .bubble_i (1'b0),
    .ctrl_d_i (ex_ctrl),
    .data_d_i (bus.ex_result),
    .ctrl_q_o (mem_ctrl),
    .data_q_o (mem_data)
  );

  // While MEM waits, WB takes a bubble so the load writes back only once.
  stage_reg #(.W(XLEN)) u_wb (
    .clk      (clk),
    .rst      (rst),
    .hold_i   (1'b0),
    .bubble_i (mem_stall),
    .ctrl_d_i (mem_ctrl),
    .data_d_i (wb_data_d),
    .ctrl_q_o (wb_ctrl),
    .data_q_o (wb_data)
  );

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((load_use || mem_stall) && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign bus.MEM_write_addr = mem_ctrl.rd;
  assign bus.WB_write_addr  = wb_ctrl.rd;
  assign bus.MEM_fwd_data   = mem_data;
  assign bus.WB_data        = wb_data;
  assign bus.MEM_RegWrite   = mem_ctrl.valid & mem_ctrl.reg_write & ~mem_ctrl.mem_read &
                              (mem_ctrl.rd != REG_ZERO);
  assign bus.WB_RegWrite    = wb_ctrl.valid & wb_ctrl.reg_write & (wb_ctrl.rd != REG_ZERO);
  assign bus.load_use_stall = load_use;
  assign bus.mem_stall      = mem_stall;
  assign bus.stall_count    = stall_cnt_q;

endmodule

// File: tb/tb_dest_tracker.sv
// Directed and random checks of dest_tracker against a cycle-level reference model.
module tb_dest_tracker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dest_tracker_if #(.XLEN(32)) bus ();

  dest_tracker #(.XLEN(32)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit        v;
    bit [4:0]  rd;
    bit        rw;
    bit        mr;
    bit [31:0] d;
  } mstage_t;

  mstage_t m_mem, m_wb;
  int      m_cnt;
  int      checks = 0;
  int      errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mem = '{default: 0};
    m_wb  = '{default: 0};
    m_cnt = 0;
  endtask

  function automatic bit exp_ms();
    return m_mem.v && m_mem.mr && !bus.mem_ready;
  endfunction

  function automatic bit exp_lus();
    if (exp_ms()) return 1'b0;
    if (!(bus.ex_valid && !bus.ex_flush && bus.ex_mem_read && bus.ex_reg_write)) return 1'b0;
    if (bus.ex_rd_addr == 0) return 1'b0;
    return (bus.ex_rd_addr == bus.id_rs1_addr) || (bus.ex_rd_addr == bus.id_rs2_addr);
  endfunction

  task automatic check_all();
    chk("mem_stall", {31'd0, bus.mem_stall}, {31'd0, exp_ms()});
    chk("load_use_stall", {31'd0, bus.load_use_stall}, {31'd0, exp_lus()});
    chk("MEM_write_addr", {27'd0, bus.MEM_write_addr}, {27'd0, m_mem.rd});
    chk("MEM_fwd_data", bus.MEM_fwd_data, m_mem.d);
    chk("MEM_RegWrite", {31'd0, bus.MEM_RegWrite},
        {31'd0, m_mem.v && m_mem.rw && !m_mem.mr && m_mem.rd != 0});
    chk("WB_RegWrite", {31'd0, bus.WB_RegWrite}, {31'd0, m_wb.v && m_wb.rw && m_wb.rd != 0});
    if (m_wb.v) begin
      chk("WB_write_addr", {27'd0, bus.WB_write_addr}, {27'd0, m_wb.rd});
      chk("WB_data", bus.WB_data, m_wb.d);
    end
    chk("stall_count", {16'd0, bus.stall_count}, m_cnt);
  endtask

  // Advance one clock: the model consumes the inputs present at the edge.
  task automatic tick();
    bit ms, lus;
    @(posedge clk);
    ms  = exp_ms();
    lus = exp_lus();
    if ((ms || lus) && m_cnt < 65535) m_cnt++;
    if (ms) begin
      m_wb.v = 0;
    end else begin
      m_wb   = m_mem;
      m_wb.d = m_mem.mr ? bus.mem_rdata : m_mem.d;
      m_mem  = '{v: bus.ex_valid && !bus.ex_flush, rd: bus.ex_rd_addr, rw: bus.ex_reg_write,
                 mr: bus.ex_mem_read, d: bus.ex_result};
    end
    #1;
  endtask

  task automatic cyc();
    #1;
    check_all();
    tick();
  endtask

  task automatic drive(input bit v, input bit f, input bit [4:0] rd, input bit rw, input bit mr,
                       input bit [31:0] res, input bit [4:0] rs1, input bit [4:0] rs2,
                       input bit rdy, input bit [31:0] rdata);
    bus.ex_valid     = v;
    bus.ex_flush     = f;
    bus.ex_rd_addr   = rd;
    bus.ex_reg_write = rw;
    bus.ex_mem_read  = mr;
    bus.ex_result    = res;
    bus.id_rs1_addr  = rs1;
    bus.id_rs2_addr  = rs2;
    bus.mem_ready    = rdy;
    bus.mem_rdata    = rdata;
  endtask

  task automatic idle(input bit rdy, input bit [31:0] rdata);
    drive(0, 0, 0, 0, 0, 32'h0, 0, 0, rdy, rdata);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #2;
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    idle(1, 0);
    #3;
    chk("rst_MEM_RegWrite", {31'd0, bus.MEM_RegWrite}, 32'd0);
    chk("rst_WB_RegWrite", {31'd0, bus.WB_RegWrite}, 32'd0);
    chk("rst_MEM_addr", {27'd0, bus.MEM_write_addr}, 32'd0);
    chk("rst_WB_addr", {27'd0, bus.WB_write_addr}, 32'd0);
    chk("rst_MEM_data", bus.MEM_fwd_data, 32'd0);
    chk("rst_WB_data", bus.WB_data, 32'd0);
    chk("rst_mem_stall", {31'd0, bus.mem_stall}, 32'd0);
    chk("rst_stall_count", {16'd0, bus.stall_count}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // ALU result travels EX -> MEM -> WB
    drive(1, 0, 5, 1, 0, 32'h10, 0, 0, 1, 0);
    cyc();
    chk("add_MEM_RegWrite", {31'd0, bus.MEM_RegWrite}, 32'd1);
    chk("add_MEM_addr", {27'd0, bus.MEM_write_addr}, 32'd5);
    chk("add_MEM_data", bus.MEM_fwd_data, 32'h10);
    idle(1, 0);
    cyc();
    chk("add_WB_RegWrite", {31'd0, bus.WB_RegWrite}, 32'd1);
    chk("add_WB_data", bus.WB_data, 32'h10);
    idle(1, 0);
    cyc();

    // Load-use detection is combinational on the EX/ID fields
    drive(1, 0, 7, 1, 1, 32'h100, 0, 7, 1, 0);
    #1;
    chk("lu_match", {31'd0, bus.load_use_stall}, 32'd1);
    bus.id_rs2_addr = 8;
    #1;
    chk("lu_nomatch", {31'd0, bus.load_use_stall}, 32'd0);
    bus.ex_rd_addr = 0;
    bus.id_rs2_addr = 0;
    #1;
    chk("lu_rd0", {31'd0, bus.load_use_stall}, 32'd0);
    idle(1, 0);
    cyc();
    cyc();

    // Load waits three cycles for memory
    do_reset();
    drive(1, 0, 3, 1, 1, 32'h200, 0, 0, 1, 0);
    cyc();
    for (int i = 0; i < 3; i++) begin
      idle(0, 32'h0);
      #1;
      chk("ld_mem_stall", {31'd0, bus.mem_stall}, 32'd1);
      chk("ld_WB_quiet", {31'd0, bus.WB_RegWrite}, 32'd0);
      cyc();
    end
    idle(1, 32'hDEADBEEF);
    cyc();
    chk("ld_WB_RegWrite", {31'd0, bus.WB_RegWrite}, 32'd1);
    chk("ld_WB_addr", {27'd0, bus.WB_write_addr}, 32'd3);
    chk("ld_WB_data", bus.WB_data, 32'hDEADBEEF);
    chk("ld_stall_count", {16'd0, bus.stall_count}, 32'd3);
    idle(1, 0);
    cyc();
    chk("ld_WB_once", {31'd0, bus.WB_RegWrite}, 32'd0);

    // Flushed instruction never writes
    drive(1, 1, 9, 1, 0, 32'h99, 0, 0, 1, 0);
    cyc();
    chk("fl_MEM_RegWrite", {31'd0, bus.MEM_RegWrite}, 32'd0);
    idle(1, 0);
    cyc();
    chk("fl_WB_RegWrite", {31'd0, bus.WB_RegWrite}, 32'd0);

    // Reset during a pending load stall discards it
    drive(1, 0, 4, 1, 1, 32'h300, 0, 0, 1, 0);
    cyc();
    idle(0, 0);
    cyc();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("rl_mem_stall", {31'd0, bus.mem_stall}, 32'd0);
    chk("rl_MEM_RegWrite", {31'd0, bus.MEM_RegWrite}, 32'd0);
    chk("rl_WB_RegWrite", {31'd0, bus.WB_RegWrite}, 32'd0);
    chk("rl_MEM_addr", {27'd0, bus.MEM_write_addr}, 32'd0);
    chk("rl_WB_addr", {27'd0, bus.WB_write_addr}, 32'd0);
    chk("rl_MEM_data", bus.MEM_fwd_data, 32'd0);
    chk("rl_WB_data", bus.WB_data, 32'd0);
    chk("rl_stall_count", {16'd0, bus.stall_count}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(1, 32'hCAFEF00D);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rl_no_write", {31'd0, bus.WB_RegWrite}, 32'd0);
    end

    // Long memory wait saturates the stall counter
    drive(1, 0, 2, 1, 1, 32'h400, 0, 0, 1, 0);
    cyc();
    idle(0, 0);
    for (int i = 0; i < 70000; i++) cyc();
    chk("sat_stall_count", {16'd0, bus.stall_count}, 32'h0000FFFF);
    idle(1, 32'h12345678);
    cyc();
    chk("sat_hold", {16'd0, bus.stall_count}, 32'h0000FFFF);

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, 5'($urandom_range(0, 7)),
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            $urandom_range(0, 3) != 0, $urandom);
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dest_tracker.md
DEST_TRACKER -- requirements
Module: dest_tracker

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath width.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port ex_valid  input  1  EX stage holds a live instruction.
REQ-005 SHALL have port ex_flush  input  1  kill the EX instruction this cycle (branch redirect).
REQ-006 SHALL have port ex_rd_addr  input  5  EX destination register.
REQ-007 SHALL have port ex_reg_write  input  1  EX instruction writes rd.
REQ-008 SHALL have port ex_mem_read  input  1  EX instruction is a load.
REQ-009 SHALL have port ex_result  input  XLEN  ALU result or load address from EX.
REQ-010 SHALL have port id_rs1_addr, id_rs2_addr  input  5 each  ID-stage source registers.
REQ-011 SHALL have port mem_ready  input  1  data memory returns load data this cycle.
REQ-012 SHALL have port mem_rdata  input  XLEN  load data, valid when mem_ready=1.
REQ-013 SHALL have port MEM_write_addr, WB_write_addr  output  5 each  stage destination registers.
REQ-014 SHALL have port MEM_RegWrite, WB_RegWrite  output  1 each  stage write enables.
REQ-015 SHALL have port MEM_fwd_data, WB_data  output  XLEN each  forwardable/writeback values.
REQ-016 SHALL have port load_use_stall  output  1  freeze PC/IF/ID, bubble into EX.
REQ-017 SHALL have port mem_stall  output  1  freeze all stages up to and including MEM.
REQ-018 SHALL have port stall_count  output  16  saturating count of stall cycles.

Function
REQ-019 SHALL hold two registered stages, MEM and WB, each {valid, rd, reg_write, mem_read, data}.
REQ-020 SHALL compute mem_stall = MEM.valid & MEM.mem_read & !mem_ready, combinationally.
REQ-021 SHALL, when mem_stall=0, load MEM from EX with valid = ex_valid & !ex_flush; latency EX->MEM one cycle.
REQ-022 SHALL, when mem_stall=1, hold MEM unchanged, ignoring ex_valid and ex_flush.
REQ-023 SHALL, when mem_stall=0, load WB from MEM with data = mem_rdata if MEM.mem_read else MEM.data.
REQ-024 SHALL, when mem_stall=1, load WB with valid=0 (bubble), so each instruction writes back exactly once.
REQ-025 SHALL drive MEM_RegWrite = MEM.valid & MEM.reg_write & !MEM.mem_read & (MEM.rd != 0); loads never forward from MEM.
REQ-026 SHALL drive WB_RegWrite = WB.valid & WB.reg_write & (WB.rd != 0).
REQ-027 SHALL drive MEM_write_addr, WB_write_addr, MEM_fwd_data and WB_data directly from stage registers regardless of valid.
REQ-028 SHALL assert load_use_stall when ex_valid & !ex_flush & ex_mem_read & ex_reg_write & ex_rd_addr != 0 and ex_rd_addr matches id_rs1_addr or id_rs2_addr.
REQ-029 SHALL force load_use_stall=0 while mem_stall=1; mem_stall takes priority.
REQ-030 SHALL increment stall_count each cycle load_use_stall | mem_stall is 1, saturating at 16'hFFFF.
REQ-031 SHALL let ex_flush and mem_stall coincide without loss: the flushed EX instruction is discarded because the EX stage is frozen and re-flushed by upstream.

Reset
REQ-032 SHALL on rst=1 clear MEM.valid and WB.valid, clear all stage fields, and clear stall_count, asynchronously.
REQ-033 SHALL as a result drive MEM_RegWrite=0, WB_RegWrite=0, all addresses/data 0, mem_stall=0 during reset.
REQ-034 SHALL on reset asserted mid-load-stall discard the pending load; no writeback occurs after release.

Structure
REQ-035 SHALL take XLEN default, the stage record typedef and REG_ZERO=5'd0 from shared package pipe_pkg.
REQ-036 SHALL instantiate sub-module stage_reg twice (MEM, WB): a stage_reg has hold/bubble controls and async clear.

Verification
REQ-037 SHALL check: ALU add, rd=5, result 0x10 at cycle 0 -> cycle 1 MEM_RegWrite=1, MEM_write_addr=5, MEM_fwd_data=0x10; cycle 2 WB_RegWrite=1, WB_data=0x10.
REQ-038 SHALL check: load rd=7 in EX, id_rs2_addr=7 -> load_use_stall=1 same cycle; with id_rs2_addr=8 -> 0; rd=0 -> 0.
REQ-039 SHALL check: load rd=3 in MEM, mem_ready low 3 cycles then high with mem_rdata=0xDEADBEEF -> mem_stall=1 for 3 cycles, WB_RegWrite=0 throughout, then one WB cycle WB_data=0xDEADBEEF, stall_count=3.
REQ-040 SHALL check: ex_flush=1 with ex_valid=1, rd=9 -> next cycle MEM_RegWrite=0 and WB_RegWrite=0 the cycle after.
REQ-041 SHALL check: rst pulsed during a pending load stall -> all outputs 0 immediately, no write after release, stall_count=0.
REQ-042 SHALL check: 70000 consecutive stall cycles -> stall_count holds at 0xFFFF.
